// File: rtl/nrisc_pkg.sv
// Shared nRISC definitions: datapath width, ALU command encodings, flag layout
// and the issue-stage FSM states.
package nrisc_pkg;

   localparam int TAM = 16;

   localparam logic [2:0] ULA_ADD = 3'b000;
   localparam logic [2:0] ULA_SUB = 3'b001;
   localparam logic [2:0] ULA_AND = 3'b010;
   localparam logic [2:0] ULA_OR  = 3'b011;
   localparam logic [2:0] ULA_XOR = 3'b100;
   localparam logic [2:0] ULA_SHR = 3'b101;
   localparam logic [2:0] ULA_SHL = 3'b110;
   localparam logic [2:0] ULA_NOT = 3'b111;

   localparam int FLAG_MINUS = 2;
   localparam int FLAG_ZERO  = 1;
   localparam int FLAG_CARRY = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Shift and rotate are the only commands issued as repeated 1-bit steps.
   function automatic logic is_iterative(input logic [2:0] ctrla);
      return (ctrla == ULA_SHR) || (ctrla == ULA_SHL);
   endfunction

endpackage

// File: rtl/nrisc_ula_seq.sv
// Issue stage in front of the combinational nRISC ALU: accepts one operation,
// replays shifts/rotates one bit per cycle through the ALU, then holds the result.
module nrisc_ula_seq
   import nrisc_pkg::state_t, nrisc_pkg::ST_IDLE, nrisc_pkg::ST_EXEC,
          nrisc_pkg::ST_DONE, nrisc_pkg::is_iterative;
#(
   parameter int TAM = nrisc_pkg::TAM
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [3:0]     in_ctrl,
   input  logic [TAM-1:0] in_a,
   input  logic [TAM-1:0] in_b,
   input  logic [3:0]     in_cnt,
   output logic [TAM-1:0] ula_a,
   output logic [TAM-1:0] ula_b,
   output logic [3:0]     ula_ctrl,
   input  logic [TAM-1:0] ula_res,
   input  logic [2:0]     ula_flags,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [TAM-1:0] out_data,
   output logic [2:0]     out_flags,
   output logic           busy
);

   state_t         r_state;
   state_t         w_state_nxt;
   logic [TAM-1:0] r_acc;
   logic [TAM-1:0] r_b;
   logic [3:0]     r_ctrl;
   logic [3:0]     r_cnt;
   logic [2:0]     r_flags;
   logic           w_accept;
   logic           w_iter;

   assign w_accept = in_valid && in_ready;
   assign w_iter   = is_iterative(in_ctrl[2:0]);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      ula_a       = '0;
      ula_b       = '0;
      ula_ctrl    = '0;
      out_data    = '0;
      out_flags   = '0;
      unique case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid)
               w_state_nxt = (w_iter && (in_cnt == 4'd0)) ? ST_DONE : ST_EXEC;
         end
         ST_EXEC: begin
            ula_a    = r_acc;
            ula_b    = r_b;
            ula_ctrl = r_ctrl;
            if (r_cnt == 4'd1) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            out_data  = r_acc;
            out_flags = r_flags;
            if (out_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: the datapath registers are few and must read as zero after reset,
   // so each one is cleared asynchronously alongside the FSM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_acc   <= '0;
         r_b     <= '0;
         r_ctrl  <= '0;
         r_cnt   <= '0;
         r_flags <= '0;
      end else if (w_accept) begin
         r_acc   <= in_a;
         r_b     <= in_b;
         r_ctrl  <= in_ctrl;
         r_cnt   <= w_iter ? in_cnt : 4'd1;
         r_flags <= '0;
      end else if (r_state == ST_EXEC) begin
         // Only the last step's flags survive; earlier ones are overwritten.
         r_acc   <= ula_res;
         r_flags <= ula_flags;
         r_cnt   <= r_cnt - 4'd1;
      end
   end

endmodule

// File: doc/nrisc_ula_seq.md
NRISC_ULA_SEQ -- requirements
Module: nrisc_ula_seq

Interface
REQ-001 SHALL provide parameter: TAM, 16, datapath width in bits.
REQ-002 SHALL provide port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL provide port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide ports: in_valid input 1, operation offered; in_ready output 1, operation accepted when both high.
REQ-005 SHALL provide ports: in_ctrl input 4, ULA command {cmd, ctrla}; in_a input TAM, operand A; in_b input TAM, operand B; in_cnt input 4, iteration count for shift/rotate.
REQ-006 SHALL provide ALU drive ports: ula_a output TAM; ula_b output TAM; ula_ctrl output 4.
REQ-007 SHALL provide ALU return ports: ula_res input TAM, combinational ALU result; ula_flags input 3, {minus, zero, carry}.
REQ-008 SHALL provide ports: out_valid output 1, result available; out_ready input 1, consumer accepts; out_data output TAM; out_flags output 3, {minus, zero, carry}.
REQ-009 SHALL provide port: busy output 1, high in any state other than IDLE.

Function
REQ-010 The block SHALL be the issue stage ahead of the combinational ALU, sequencing multi-bit shifts and rotates as repeated 1-bit ALU operations.
REQ-011 The FSM SHALL have states IDLE, EXEC and DONE.
REQ-012 In IDLE, in_ready SHALL be 1; in_ready SHALL be 0 in EXEC and DONE, so only one operation is in flight.
REQ-013 On accept, the block SHALL latch ctrl, b and cnt into registers, load in_a into accumulator acc, and enter EXEC.
REQ-014 On accept, the remaining count SHALL be set to in_cnt when ctrla is 101 or 110, and to 1 otherwise.
REQ-015 On accept of a shift/rotate (ctrla 101 or 110) with in_cnt=0, the block SHALL go directly to DONE with out_data=in_a and out_flags=000, without driving the ALU.
REQ-016 In EXEC, the block SHALL drive ula_a=acc, ula_b=b_reg and ula_ctrl=ctrl_reg.
REQ-017 In EXEC, each cycle SHALL capture ula_res into acc, capture ula_flags into the flag register, and decrement the remaining count.
REQ-018 When EXEC captures with remaining count = 1, the block SHALL enter DONE.
REQ-019 Latency from accept to out_valid SHALL be 2 cycles for non-shift ops, N+1 cycles for shift/rotate with N≥1, and 1 cycle for N=0.
REQ-020 out_flags SHALL equal the flags of the final ALU iteration only; flags SHALL NOT be accumulated across iterations.
REQ-021 In DONE, out_valid SHALL be 1, and out_data and out_flags SHALL hold stable until out_ready=1.
REQ-022 The block SHALL return to IDLE on the cycle after out_valid&&out_ready.
REQ-023 in_ready SHALL NOT assert in the same cycle as the DONE handshake.
REQ-024 in_valid arriving while busy SHALL be ignored, and its inputs SHALL NOT be sampled.
REQ-025 Outside EXEC, ula_a, ula_b and ula_ctrl SHALL be driven to 0.
REQ-026 The count field SHALL be 4 bits unsigned; counts ≥ TAM SHALL be executed literally with no saturation.

Reset
REQ-027 When rst=0, the block SHALL asynchronously force the FSM to IDLE regardless of the clock.
REQ-028 When rst=0, acc, b_reg, ctrl_reg, the count and the flag register SHALL be cleared to 0.
REQ-029 Reset values SHALL be: in_ready=1 after release, out_valid=0, busy=0, out_data=0, out_flags=000, ula_*=0.
REQ-030 Reset asserted in EXEC or DONE SHALL abort the operation with no output handshake.
REQ-031 After reset release, the block SHALL accept a new operation on the first rising edge.

Structure
REQ-032 Shared package nrisc_pkg SHALL hold TAM, the ctrla encodings (000 add through 111 not), the flag bit indices (minus=2, zero=1, carry=0) and the FSM state enum.
REQ-033 The ALU SHALL be instantiated by the parent; nrisc_ula_seq SHALL contain no sub-modules.

Verification
REQ-034 ADD: ctrl=0000, a=0x0003, b=0x0004 → out_valid 2 cycles after accept, out_data=0x0007, flags from ALU model.
REQ-035 Shift left by 3: ctrl=0110, a=0x0001, cnt=3 → ula_ctrl=0110 for 3 EXEC cycles, out_data=0x0008 at accept+4.
REQ-036 Zero count: ctrl=0101, a=0xBEEF, cnt=0 → out_valid at accept+1, out_data=0xBEEF, flags=000, ula_* stay 0.
REQ-037 Backpressure: out_ready=0 for 5 cycles in DONE → out_data and out_flags stable, in_ready=0, in_valid pulse ignored; IDLE one cycle after out_ready=1.
REQ-038 Reset mid-op: rst=0 during the 2nd EXEC cycle of cnt=5 → immediate out_valid=0, busy=0, out_data=0; next op after release completes correctly.
